// File: rtl/ascon_perm_scheduler.sv
// ASCON permutation sequencer: owns the 320-bit working state, round index and start/done handshake.
// Optional p8 mode is compiled in when ASCON_PERM_P8_EN is defined.
module ascon_perm_scheduler #(
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       nb_rounds_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] rnd_state_o,
    output logic [3:0]       round_idx_o,
    input  logic [4:0][63:0] rnd_state_i,
    output logic [4:0][63:0] state_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    localparam logic [3:0] LAST_IDX = 4'd11;

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       idx_q, idx_d;
    logic [4:0][63:0] state_reg_q, state_reg_d;
    logic             accept;
    logic             last_round;

    // Every mode ends on index 11, so a shorter permutation just starts later.
    function automatic logic [3:0] first_idx(input logic [1:0] mode);
        logic [3:0] f;
        case (mode)
            2'b01:   f = 4'd6;
`ifdef ASCON_PERM_P8_EN
            2'b10:   f = 4'd4;
`endif
            default: f = 4'd0;
        endcase
        return f;
    endfunction

    assign accept     = start_i && ready_o;
    assign last_round = (fsm_q == S_RUN) && (idx_q == LAST_IDX);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (start_i) fsm_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) fsm_d = S_DONE;
            S_DONE:  fsm_d = start_i ? S_RUN : S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (fsm_q)
            S_IDLE:  ready_o = 1'b1;
            S_RUN:   busy_o  = 1'b1;
            S_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            default: ready_o = 1'b1;
        endcase
    end

    always_comb begin
        state_reg_d = state_reg_q;
        idx_d       = idx_q;
        if (accept) begin
            state_reg_d = state_i;
            idx_d       = first_idx(nb_rounds_i);
        end else if (fsm_q == S_RUN) begin
            state_reg_d = rnd_state_i;
            idx_d       = (idx_q == LAST_IDX) ? idx_q : idx_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg_q <= '0;
            idx_q       <= '0;
        end else begin
            state_reg_q <= state_reg_d;
            idx_q       <= idx_d;
        end
    end

    assign rnd_state_o = state_reg_q;
    assign round_idx_o = idx_q;

    generate
        if (HOLD_OUTPUT) begin : g_hold
            logic [4:0][63:0] result_q;

            // Captured only on the final round so the result survives the next job's rounds.
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    result_q <= '0;
                end else if (last_round) begin
                    result_q <= rnd_state_i;
                end
            end

            assign state_o = result_q;
        end else begin : g_follow
            assign state_o = state_reg_q;
        end
    endgenerate

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Bench for ascon_perm_scheduler: job-level timing model checked every cycle plus directed literal checks.
module tb_ascon_perm_scheduler;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic [1:0]       nb_rounds_i;
    logic [4:0][63:0] state_i;
    logic [4:0][63:0] rnd_state_o;
    logic [3:0]       round_idx_o;
    logic [4:0][63:0] rnd_state_i;
    logic [4:0][63:0] state_o;
    logic             ready_o, busy_o, done_o;

    always #5 clk = ~clk;

    ascon_perm_scheduler dut (
        .clock_i     (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .nb_rounds_i (nb_rounds_i),
        .state_i     (state_i),
        .rnd_state_o (rnd_state_o),
        .round_idx_o (round_idx_o),
        .rnd_state_i (rnd_state_i),
        .state_o     (state_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Toy round: XOR the round index into word 2.
    always_comb begin
        rnd_state_i    = rnd_state_o;
        rnd_state_i[2] = rnd_state_o[2] ^ {60'h0, round_idx_o};
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] xr(input int a, input int b);
        logic [3:0] x = 4'h0;
        for (int i = a; i <= b; i++) x ^= 4'(i);
        return x;
    endfunction

    function automatic int rounds_of(input logic [1:0] m);
        if (m == 2'b01) return 6;
`ifdef ASCON_PERM_P8_EN
        if (m == 2'b10) return 8;
`endif
        return 12;
    endfunction

    // Job model: one accepted start at edge t0 runs n rounds; done follows edge t0+n.
    int               e = 0;
    bit               model_ok = 1'b0;
    bit               m_active = 1'b0;
    int               m_t0 = 0;
    int               m_n = 12;
    int               m_f = 0;
    logic [4:0][63:0] m_in  = '0;
    logic [4:0][63:0] m_res = '0;
    logic [4:0][63:0] m_out = '0;
    int               dut_dones = 0;

    always @(posedge clk) begin
        int  d_prev;
        bit  rdy_prev;
        e = e + 1;
        d_prev   = e - 1 - m_t0;
        rdy_prev = !m_active || (d_prev >= m_n);
        if (reset_i) begin
            model_ok = 1'b1;
            m_active = 1'b0;
            m_out    = '0;
        end else if (start_i && rdy_prev) begin
            m_active  = 1'b1;
            m_t0      = e;
            m_n       = rounds_of(nb_rounds_i);
            m_f       = 12 - m_n;
            m_in      = state_i;
            m_res     = state_i;
            m_res[2]  = state_i[2] ^ {60'h0, xr(m_f, 11)};
        end
        if (!reset_i && m_active && (e - m_t0 == m_n)) m_out = m_res;
    end

    always @(negedge clk) begin
        int               d;
        logic             x_ready, x_busy, x_done;
        logic [3:0]       x_idx;
        logic [4:0][63:0] x_work;
        if (done_o === 1'b1) dut_dones++;
        if (model_ok) begin
            d = e - m_t0;
            if (!m_active) begin
                x_ready = 1'b1; x_busy = 1'b0; x_done = 1'b0;
                x_idx = 4'd0; x_work = '0;
            end else if (d < m_n) begin
                x_ready = 1'b0; x_busy = 1'b1; x_done = 1'b0;
                x_idx = 4'(m_f + d);
                x_work = m_in;
                x_work[2] = m_in[2] ^ {60'h0, xr(m_f, m_f + d - 1)};
            end else begin
                x_ready = 1'b1; x_busy = 1'b0; x_done = (d == m_n);
                x_idx = 4'd11; x_work = m_res;
            end
            check("ready_o", 320'(ready_o), 320'(x_ready));
            check("busy_o", 320'(busy_o), 320'(x_busy));
            check("done_o", 320'(done_o), 320'(x_done));
            check("round_idx_o", 320'(round_idx_o), 320'(x_idx));
            check("rnd_state_o", rnd_state_o, x_work);
            check("state_o", state_o, m_out);
        end
    end

    task automatic wait_done(input string nm, output int edone);
        bit seen = 1'b0;
        edone = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen  = 1'b1;
                edone = e;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done_o required done_o within 40 cycles", nm);
        end
    endtask

    task automatic run_job(input logic [1:0] mode, input logic [4:0][63:0] s,
                           input int lat, input string nm);
        int t0, ed;
        @(negedge clk);
        start_i = 1'b1; nb_rounds_i = mode; state_i = s;
        @(posedge clk); #1;
        t0 = e;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(nm, ed);
        check({nm, "_latency"}, 320'(ed - t0 + 1), 320'(lat));
    endtask

    logic [4:0][63:0] s;
    int t0, ed1, ed2, dones_before;

    initial begin
        reset_i = 1'b1; start_i = 1'b0; nb_rounds_i = 2'b00; state_i = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check("rst_ready", 320'(ready_o), 320'(1));
        check("rst_busy", 320'(busy_o), 320'(0));
        check("rst_done", 320'(done_o), 320'(0));
        check("rst_idx", 320'(round_idx_o), 320'(0));
        check("rst_state_o", state_o, 320'(0));

        s = '0;
        run_job(2'b00, s, 13, "p12");
        check("p12_word2", 320'(state_o[2]), 320'(64'h0));

        s = '0; s[0] = 64'h0123456789ABCDEF; s[2] = 64'hFF; s[4] = 64'hDEADBEEF00C0FFEE;
        run_job(2'b01, s, 7, "p6");
        check("p6_word2", 320'(state_o[2]), 320'(64'hFE));
        check("p6_word0", 320'(state_o[0]), 320'(64'h0123456789ABCDEF));
        check("p6_word4", 320'(state_o[4]), 320'(64'hDEADBEEF00C0FFEE));

        s = '0; s[2] = 64'h5A;
`ifdef ASCON_PERM_P8_EN
        run_job(2'b10, s, 9, "p8");
`else
        run_job(2'b10, s, 13, "p8_as_p12");
`endif
        check("p8_word2", 320'(state_o[2]), 320'(64'h5A));

        s = '0; s[1] = 64'h77;
        run_job(2'b11, s, 13, "reserved");
        check("reserved_word1", 320'(state_o[1]), 320'(64'h77));

        // Back-to-back p6 jobs with start held high.
        @(negedge clk);
        s = '0; s[2] = 64'h33;
        start_i = 1'b1; nb_rounds_i = 2'b01; state_i = s;
        @(posedge clk); #1;
        @(negedge clk);
        s = '0; s[2] = 64'h100;
        state_i = s;
        wait_done("b2b_first", ed1);
        check("b2b_first_word2", 320'(state_o[2]), 320'(64'h32));
        @(posedge clk); #1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("b2b_second", ed2);
        check("b2b_done_spacing", 320'(ed2 - ed1), 320'(7));
        check("b2b_second_word2", 320'(state_o[2]), 320'(64'h101));

        // Start pulsed mid-RUN must not disturb the running p12 job.
        @(negedge clk);
        s = '0; s[3] = 64'hCAFE;
        start_i = 1'b1; nb_rounds_i = 2'b00; state_i = s;
        @(posedge clk); #1;
        t0 = e;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1; nb_rounds_i = 2'b01; state_i = '1;
        @(negedge clk);
        start_i = 1'b0; state_i = '0;
        wait_done("midstart", ed1);
        check("midstart_latency", 320'(ed1 - t0 + 1), 320'(13));
        check("midstart_word3", 320'(state_o[3]), 320'(64'hCAFE));

        // Reset while the round index is 5.
        @(negedge clk);
        s = '0; s[1] = 64'h1234;
        start_i = 1'b1; nb_rounds_i = 2'b00; state_i = s;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20 && round_idx_o !== 4'd5; i++) @(negedge clk);
        check("rst_mid_reached_idx5", 320'(round_idx_o), 320'(5));
        dones_before = dut_dones;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("rst_mid_ready", 320'(ready_o), 320'(1));
        check("rst_mid_busy", 320'(busy_o), 320'(0));
        check("rst_mid_state_o", state_o, 320'(0));
        check("rst_mid_idx", 320'(round_idx_o), 320'(0));
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", 320'(dut_dones - dones_before), 320'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
